// File: rtl/delay_line_rt.sv
// delay_line_rt: run-time programmable multi-channel delay line with a travelling valid bit.
// Behaves like d cascaded clock-enabled registers, built from a circular buffer plus one
// output register. The read offset is d-1 because the output register supplies the last stage.
// When d=1 the sample being written on this edge is forwarded straight to the output register.
module delay_line_rt #(
    parameter int DATA_WIDTH  = 12,
    parameter int CHANNELS    = 3,
    parameter int MAX_DLY     = 32,
    parameter int DEFAULT_DLY = 18
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_en,
    input  logic                           i_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
    input  logic                           i_flush,
    input  logic                           i_cfg_we,
    input  logic [$clog2(MAX_DLY+1)-1:0]   i_cfg_dly,
    output logic                           o_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_data,
    output logic [$clog2(MAX_DLY+1)-1:0]   o_dly
);

    localparam int DLY_W  = $clog2(MAX_DLY + 1);
    localparam int PTR_W  = $clog2(MAX_DLY);
    localparam int WORD_W = CHANNELS * DATA_WIDTH;
    localparam logic [PTR_W:0]   MAX_EXT  = (PTR_W + 1)'(MAX_DLY);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_DLY - 1);

    logic [WORD_W-1:0]  mem [MAX_DLY];
    logic [MAX_DLY-1:0] valid_q;
    logic [MAX_DLY-1:0] valid_d;
    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   rd_idx;
    logic [PTR_W:0]     rd_sum;
    logic [PTR_W:0]     rd_wrap;
    logic [DLY_W-1:0]   dly;
    logic [DLY_W-1:0]   dly_m1;
    logic [DLY_W-1:0]   cfg_clamped;
    logic               rd_valid;
    logic [WORD_W-1:0]  rd_data;
    logic               clear_all;

    assign clear_all = i_flush | i_cfg_we;
    assign o_dly     = dly;

    // Clamp the requested delay into the legal range 1..MAX_DLY.
    always_comb begin
        cfg_clamped = i_cfg_dly;
        if (i_cfg_dly == '0) begin
            cfg_clamped = DLY_W'(1);
        end else if (i_cfg_dly > DLY_W'(MAX_DLY)) begin
            cfg_clamped = DLY_W'(MAX_DLY);
        end
    end

    // Locate the entry that leaves the line on this edge: (wp - (d-1)) mod MAX_DLY, or the live input when d=1.
    always_comb begin
        dly_m1  = dly - DLY_W'(1);
        rd_sum  = {1'b0, wp} + MAX_EXT - (PTR_W + 1)'(dly_m1);
        rd_wrap = rd_sum - MAX_EXT;
        rd_idx  = (rd_sum >= MAX_EXT) ? rd_wrap[PTR_W-1:0] : rd_sum[PTR_W-1:0];
        if (dly_m1 == '0) begin
            rd_valid = i_valid;
            rd_data  = i_data;
        end else begin
            rd_valid = valid_q[rd_idx];
            rd_data  = mem[rd_idx];
        end
    end

    // Next entry-valid vector: clear everything on flush/load, then record the sample written this edge.
    always_comb begin
        valid_d = clear_all ? '0 : valid_q;
        if (i_en) begin
            valid_d[wp] = i_valid;
        end
    end

    // Entry valid bits and the write pointer, which wraps modulo MAX_DLY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            wp      <= '0;
        end else begin
            valid_q <= valid_d;
            if (i_en) begin
                wp <= (wp == LAST_PTR) ? '0 : wp + PTR_W'(1);
            end
        end
    end

    // Delay in effect; a load applies whether or not the line is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly <= DLY_W'(DEFAULT_DLY);
        end else if (i_cfg_we) begin
            dly <= cfg_clamped;
        end
    end

    // Output register: cleared by flush/load, otherwise loads the read entry with data gated by its valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (clear_all) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_en) begin
            o_valid <= rd_valid;
            o_data  <= rd_valid ? rd_data : '0;
        end
    end

    // Sample storage has no reset; stale contents are masked by the entry valid bits.
    always_ff @(posedge clk) begin
        if (i_en) begin
            mem[wp] <= i_data;
        end
    end

endmodule

// File: tb/tb_delay_line_rt.sv
// Testbench for delay_line_rt: directed scenarios with literal expectations plus a randomized
// soak, all checked every cycle against an epoch-based model of d cascaded enabled registers.
module tb_delay_line_rt;

    localparam int DATA_WIDTH  = 12;
    localparam int CHANNELS    = 3;
    localparam int MAX_DLY     = 32;
    localparam int DEFAULT_DLY = 18;
    localparam int DLY_W       = $clog2(MAX_DLY + 1);
    localparam int WORD_W      = CHANNELS * DATA_WIDTH;
    localparam int HSZ         = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_en = 1'b0;
    logic              i_valid = 1'b0;
    logic [WORD_W-1:0] i_data = '0;
    logic              i_flush = 1'b0;
    logic              i_cfg_we = 1'b0;
    logic [DLY_W-1:0]  i_cfg_dly = '0;
    logic              o_valid;
    logic [WORD_W-1:0] o_data;
    logic [DLY_W-1:0]  o_dly;

    int assertions = 0;
    int failures   = 0;

    // Reference model: history of samples indexed by enabled-edge count and an epoch marking the oldest live sample.
    int                n_en   = 0;
    int                epoch  = 1;
    int                m_dly  = DEFAULT_DLY;
    logic              m_valid = 1'b0;
    logic [WORD_W-1:0] m_data  = '0;
    logic              h_valid [HSZ];
    logic [WORD_W-1:0] h_data  [HSZ];

    delay_line_rt #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNELS   (CHANNELS),
        .MAX_DLY    (MAX_DLY),
        .DEFAULT_DLY(DEFAULT_DLY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_en     (i_en),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .i_flush  (i_flush),
        .i_cfg_we (i_cfg_we),
        .i_cfg_dly(i_cfg_dly),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_dly    (o_dly)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] pack(input int v);
        return {12'(v + 2048), 12'(v + 1024), 12'(v)};
    endfunction

    function automatic int clampDly(input int v);
        if (v == 0) return 1;
        if (v > MAX_DLY) return MAX_DLY;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [WORD_W-1:0] data,
                                 input logic flush, input logic we, input logic [DLY_W-1:0] cfg);
        @(negedge clk);
        i_en      = en;
        i_valid   = valid;
        i_data    = data;
        i_flush   = flush;
        i_cfg_we  = we;
        i_cfg_dly = cfg;
        @(posedge clk);
        #1;
    endtask

    // Model update: output after an enabled edge is the sample from d-1 enabled edges earlier, if it is in the live epoch.
    always @(posedge clk or posedge rst) begin
        int k;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_dly   = DEFAULT_DLY;
            epoch   = n_en + 1;
        end else begin
            if (i_en) begin
                n_en++;
                h_valid[n_en % HSZ] = i_valid;
                h_data[n_en % HSZ]  = i_data;
            end
            if (i_cfg_we) m_dly = clampDly(int'(i_cfg_dly));
            if (i_flush || i_cfg_we) begin
                epoch   = i_en ? n_en : n_en + 1;
                m_valid = 1'b0;
                m_data  = '0;
            end else if (i_en) begin
                k = n_en - m_dly + 1;
                if (k >= epoch) begin
                    m_valid = h_valid[k % HSZ];
                    m_data  = m_valid ? h_data[k % HSZ] : '0;
                end else begin
                    m_valid = 1'b0;
                    m_data  = '0;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("model o_valid", 64'(o_valid), 64'(m_valid));
            checkOutput("model o_data", 64'(o_data), 64'(m_data));
            checkOutput("model o_dly", 64'(o_dly), 64'(m_dly));
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset o_valid", 64'(o_valid), 64'd0);
        checkOutput("reset o_data", 64'(o_data), 64'd0);
        checkOutput("reset o_dly", 64'(o_dly), 64'(DEFAULT_DLY));

        // Default delay ramp across pointer wrap.
        for (int i = 1; i <= 110; i++) begin
            applyStimulus(1'b1, 1'b1, pack(i), 1'b0, 1'b0, '0);
            if (i == 17) checkOutput("ramp not yet valid", 64'(o_valid), 64'd0);
            if (i == 18) checkOutput("ramp first sample", 64'(o_data), 64'(pack(1)));
            if (i == 18) checkOutput("ramp first valid", 64'(o_valid), 64'd1);
            if (i == 100) checkOutput("ramp after wrap", 64'(o_data), 64'(pack(83)));
        end

        // d=4 with clock enable toggling.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, DLY_W'(4));
        checkOutput("load 4 o_dly", 64'(o_dly), 64'd4);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'(i % 2), 1'b1, pack(100 + i), 1'b0, 1'b0, '0);
            if (i == 6) checkOutput("ce not yet valid", 64'(o_valid), 64'd0);
            if (i == 7) checkOutput("ce first sample", 64'(o_data), 64'(pack(101)));
            if (i == 8) checkOutput("ce hold", 64'(o_data), 64'(pack(101)));
            if (i == 9) checkOutput("ce second sample", 64'(o_data), 64'(pack(103)));
        end

        // Clamp of 0 and exact 1, then clamp above maximum.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, DLY_W'(0));
        checkOutput("load 0 o_dly", 64'(o_dly), 64'd1);
        applyStimulus(1'b1, 1'b1, pack(500), 1'b0, 1'b0, '0);
        checkOutput("d1 latency", 64'(o_data), 64'(pack(500)));
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, DLY_W'(1));
        checkOutput("load 1 clears", 64'(o_valid), 64'd0);
        applyStimulus(1'b1, 1'b1, pack(501), 1'b0, 1'b0, '0);
        checkOutput("d1 again", 64'(o_data), 64'(pack(501)));
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, DLY_W'(40));
        checkOutput("load 40 o_dly", 64'(o_dly), 64'd32);
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1'b1, 1'b1, pack(600 + i), 1'b0, 1'b0, '0);
            if (i == 31) checkOutput("d32 still low", 64'(o_valid), 64'd0);
            if (i == 32) checkOutput("d32 first sample", 64'(o_data), 64'(pack(601)));
        end

        // Mid-stream flush at d=5.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, DLY_W'(5));
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 1'b1, pack(700 + i), 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, pack(777), 1'b1, 1'b0, '0);
        checkOutput("flush drops valid", 64'(o_valid), 64'd0);
        for (int j = 1; j <= 4; j++) begin
            applyStimulus(1'b1, 1'b1, pack(780 + j), 1'b0, 1'b0, '0);
            if (j == 3) checkOutput("flush gap", 64'(o_valid), 64'd0);
            if (j == 4) checkOutput("flush sample out", 64'(o_data), 64'(pack(777)));
        end

        // Simultaneous flush and load 5 -> 3.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1, pack(800 + i), 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, pack(888), 1'b1, 1'b1, DLY_W'(3));
        checkOutput("flush+load o_dly", 64'(o_dly), 64'd3);
        applyStimulus(1'b1, 1'b1, pack(889), 1'b0, 1'b0, '0);
        checkOutput("flush+load gap", 64'(o_valid), 64'd0);
        applyStimulus(1'b1, 1'b1, pack(890), 1'b0, 1'b0, '0);
        checkOutput("flush+load sample", 64'(o_data), 64'(pack(888)));

        // Randomized soak.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), WORD_W'({$urandom, $urandom}),
                          1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 3),
                          DLY_W'($urandom_range(0, 63)));
        end

        // Asynchronous reset mid-stream.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, DLY_W'(6));
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 1'b1, pack(950 + i), 1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async reset o_valid", 64'(o_valid), 64'd0);
        checkOutput("async reset o_data", 64'(o_data), 64'd0);
        checkOutput("async reset o_dly", 64'(o_dly), 64'(DEFAULT_DLY));
        i_en    = 1'b0;
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(1'b1, 1'b1, pack(1500 + i), 1'b0, 1'b0, '0);
            if (i == 17) checkOutput("post reset gap", 64'(o_valid), 64'd0);
            if (i == 18) checkOutput("post reset first", 64'(o_data), 64'(pack(1501)));
        end
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WORD_W'({$urandom, $urandom}),
                          1'b0, 1'b0, '0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
